vend_sequencer: RTL



---
 rtl/vend_pkg.sv | 40 ++++
 rtl/vend_sequencer_if.sv | 21 ++
 rtl/act_timer.sv | 27 ++
 rtl/vend_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vend sequencer: FSM states, actuator
// select codes, drink codes, coin values and the price lookup.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DRINK,
    ST_COIN,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam logic [1:0] ACT_DRINK1   = 2'd0;
  localparam logic [1:0] ACT_DRINK2   = 2'd1;
  localparam logic [1:0] ACT_COIN_1Y  = 2'd2;
  localparam logic [1:0] ACT_COIN_05Y = 2'd3;

  localparam logic [1:0] DRINK_1 = 2'b01;
  localparam logic [1:0] DRINK_2 = 2'b10;

  // Coin values in units of 0.5 yuan
  localparam logic [5:0] COIN_1Y_VAL  = 6'd2;
  localparam logic [5:0] COIN_05Y_VAL = 6'd1;

  localparam int TMR_W = 8;

  // Cancel codes (00/11) price to zero so the whole sum is refunded
  function automatic logic [5:0] price_of(input logic [1:0] drink,
                                          input logic [5:0] p1,
                                          input logic [5:0] p2);
    case (drink)
      DRINK_1: return p1;
      DRINK_2: return p2;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Purchase request handshake plus the shared dispense actuator bus.
// master = sequencer side, slave = purchase FSM / mechanism side.
interface vend_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_drink;
  logic [5:0] req_sum;
  logic       act_valid;
  logic [1:0] act_sel;
  logic       act_ack;

  modport master (
    input  req_valid, req_drink, req_sum, act_ack,
    output req_ready, act_valid, act_sel
  );

  modport slave (
    output req_valid, req_drink, req_sum, act_ack,
    input  req_ready, act_valid, act_sel
  );
endinterface

// File: rtl/act_timer.sv
// Single down-counter shared by the inter-pulse gap and the ack timeout.
// expire fires in the last counted cycle so the FSM can leave on that edge.
module act_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign expire = (cnt_reg == W'(1));

endmodule

// File: rtl/vend_sequencer.sv
// Vend sequencer: accepts one purchase, then drives the drink gate and the
// change coins (largest first) over the shared actuator bus.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_1     = 5,
  parameter int PRICE_2     = 10,
  parameter int PULSE_GAP   = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vend_sequencer_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 short_flag,
  output logic [5:0]           change_left,
  output logic                 fault
);

  state_t           state_reg, state_next;
  logic [1:0]       drink_reg;
  logic [5:0]       sum_reg;
  logic [5:0]       change_reg, change_next;
  logic             short_reg, short_next;
  logic             act_on;
  logic [1:0]       act_code;
  logic             tmr_start;
  logic [TMR_W-1:0] tmr_load;
  logic             tmr_expire;
  logic [5:0]       price;
  logic             drink_ok;
  logic [5:0]       coin_val;

  act_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tmr_start),
    .load_val (tmr_load),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      drink_reg  <= '0;
      sum_reg    <= '0;
      change_reg <= '0;
      short_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      change_reg <= change_next;
      short_reg  <= short_next;
      if (state_reg == ST_IDLE && bus.req_valid) begin
        drink_reg <= bus.req_drink;
        sum_reg   <= bus.req_sum;
      end
    end
  end

  assign price    = price_of(drink_reg, 6'(PRICE_1), 6'(PRICE_2));
  assign drink_ok = (drink_reg == DRINK_1) || (drink_reg == DRINK_2);
  assign coin_val = (change_reg >= COIN_1Y_VAL) ? COIN_1Y_VAL : COIN_05Y_VAL;

  always_comb begin
    state_next  = state_reg;
    change_next = change_reg;
    short_next  = short_reg;
    act_on      = 1'b0;
    act_code    = ACT_DRINK1;
    tmr_start   = 1'b0;
    tmr_load    = TMR_W'(ACK_TIMEOUT);

    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          short_next = 1'b0;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (drink_ok && sum_reg >= price) begin
          change_next = sum_reg - price;
          state_next  = ST_DRINK;
          tmr_start   = 1'b1;
        end else begin
          // Short or cancelled: refund everything, flag only a real shortfall
          change_next = sum_reg;
          short_next  = drink_ok;
          if (sum_reg != '0) begin
            state_next = ST_COIN;
            tmr_start  = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DRINK: begin
        act_on   = 1'b1;
        act_code = (drink_reg == DRINK_2) ? ACT_DRINK2 : ACT_DRINK1;
        if (bus.act_ack) begin
          state_next = ST_GAP;
          tmr_start  = 1'b1;
          tmr_load   = TMR_W'(PULSE_GAP);
        end else if (tmr_expire) begin
          state_next = ST_FAULT;
        end
      end
      ST_COIN: begin
        act_on   = 1'b1;
        act_code = (change_reg >= COIN_1Y_VAL) ? ACT_COIN_1Y : ACT_COIN_05Y;
        if (bus.act_ack) begin
          change_next = change_reg - coin_val;
          state_next  = ST_GAP;
          tmr_start   = 1'b1;
          tmr_load    = TMR_W'(PULSE_GAP);
        end else if (tmr_expire) begin
          state_next = ST_FAULT;
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          if (change_reg != '0) begin
            state_next = ST_COIN;
            tmr_start  = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.act_valid = act_on;
  assign bus.act_sel   = act_code;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);
  assign fault         = (state_reg == ST_FAULT);
  assign short_flag    = short_reg;
  assign change_left   = change_reg;

endmodule
